// File: rtl/alu_mdu.sv
// alu_mdu: single-cycle ALU plus iterative WIDTH-cycle multiply/divide unit with HI/LO registers.
module alu_mdu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alucontrol,
  input  logic             start,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             busy,
  output logic             done
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [SHW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, mcand_q, mcand_d;
  logic [2*WIDTH-1:0] p_q, p_d, step, fin;
  logic div_q, div_d, neg_q, neg_d, done_q, done_d;
  logic [WIDTH:0] sum, shifted, diff;
  logic [WIDTH-1:0] add_r, sub_r, ma, mb;
  logic accept, is_mult;
  assign add_r = a + b;
  assign sub_r = a - b;
  always_comb begin
    result   = '0;
    overflow = 1'b0;
    case (alucontrol)
      4'b0000: result = a & b;
      4'b0001: result = a | b;
      4'b0010: begin
        result   = add_r;
        overflow = (a[WIDTH-1] == b[WIDTH-1]) && (add_r[WIDTH-1] != a[WIDTH-1]);
      end
      4'b0110: begin
        result   = sub_r;
        overflow = (a[WIDTH-1] != b[WIDTH-1]) && (sub_r[WIDTH-1] != a[WIDTH-1]);
      end
      4'b0111: result = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      4'b0101: result = {{(WIDTH-1){1'b0}}, a < b};
      4'b0011: result = a ^ b;
      4'b0100: result = ~(a | b);
      4'b1000: result = b << a[SHW-1:0];
      4'b1001: result = b >> a[SHW-1:0];
      4'b1010: result = $signed(b) >>> a[SHW-1:0];
      4'b1011: result = hi_q;
      4'b1100: result = lo_q;
      default: result = '0;
    endcase
  end
  assign zero = result == '0;
  assign busy = state_q == RUN;
  assign done = done_q;
  assign is_mult = alucontrol == 4'b1111;
  assign accept  = state_q == IDLE && start && alucontrol[3:2] == 2'b11 && alucontrol[1:0] != 2'b00;
  assign ma = (is_mult && a[WIDTH-1]) ? -a : a;
  assign mb = (is_mult && b[WIDTH-1]) ? -b : b;
  // p_q holds {accumulator, multiplier} for multiply and {remainder, quotient} for divide
  assign sum     = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, p_q[0] ? mcand_q : '0};
  assign shifted = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, mcand_q};
  assign step = div_q ? (diff[WIDTH] ? {shifted[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0}
                                     : {diff[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1})
                      : {sum, p_q[WIDTH-1:1]};
  assign fin = neg_q ? -step : step;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    mcand_d = mcand_q;
    div_d   = div_q;
    neg_d   = neg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    if (accept) begin
      state_d = RUN;
      cnt_d   = '0;
      p_d     = {{WIDTH{1'b0}}, ma};
      mcand_d = mb;
      div_d   = alucontrol == 4'b1110;
      neg_d   = is_mult && (a[WIDTH-1] ^ b[WIDTH-1]);
    end else if (state_q == RUN) begin
      p_d   = step;
      cnt_d = cnt_q + SHW'(1);
      if (cnt_q == SHW'(WIDTH-1)) begin
        state_d      = IDLE;
        {hi_d, lo_d} = fin;
        done_d       = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      mcand_q <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      mcand_q <= mcand_d;
      div_q   <= div_d;
      neg_q   <= neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end
endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: randomized scoreboard bench for alu_mdu against a plain-arithmetic reference model.
module tb_alu_mdu;
  localparam int W = 32;
  localparam logic [3:0] MFHI = 4'b1011, MFLO = 4'b1100, MULTU = 4'b1101, DIVU = 4'b1110, MULT = 4'b1111;
  localparam longint MAXS = 64'sd2147483647;
  localparam longint MINS = -64'sd2147483648;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [W-1:0] a = '0, b = '0, result;
  logic [3:0] alucontrol = '0;
  logic zero, overflow, busy, done;
  int checks = 0, failures = 0;
  logic [63:0] sb[$];
  logic [W-1:0] hi_m = '0, lo_m = '0;

  alu_mdu #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .alucontrol(alucontrol), .start(start),
    .result(result), .zero(zero), .overflow(overflow), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  function automatic logic [W:0] ref_alu(input logic [3:0] c, input logic [W-1:0] x, y);
    longint s;
    logic [W-1:0] r;
    logic o;
    r = '0;
    o = 1'b0;
    s = 0;
    case (c)
      4'd0: r = x & y;
      4'd1: r = x | y;
      4'd2: begin r = x + y; s = longint'($signed(x)) + longint'($signed(y)); o = s > MAXS || s < MINS; end
      4'd6: begin r = x - y; s = longint'($signed(x)) - longint'($signed(y)); o = s > MAXS || s < MINS; end
      4'd7: r = ($signed(x) < $signed(y)) ? 1 : 0;
      4'd5: r = (x < y) ? 1 : 0;
      4'd3: r = x ^ y;
      4'd4: r = ~(x | y);
      4'd8: r = y << x[4:0];
      4'd9: r = y >> x[4:0];
      4'd10: r = $unsigned($signed(y) >>> x[4:0]);
      4'd11: r = hi_m;
      4'd12: r = lo_m;
      default: r = '0;
    endcase
    return {o, r};
  endfunction

  function automatic logic [63:0] ref_mdu(input logic [3:0] c, input logic [W-1:0] x, y);
    longint p;
    if (c == MULTU) return 64'(x) * 64'(y);
    if (c == MULT) begin
      p = longint'($signed(x)) * longint'($signed(y));
      return 64'(p);
    end
    return (y == 0) ? {x, 32'hFFFF_FFFF} : {x % y, x / y};
  endfunction

  task automatic comb(input logic [3:0] c, input logic [W-1:0] x, y);
    logic [W:0] e;
    alucontrol = c;
    a = x;
    b = y;
    #1;
    e = ref_alu(c, x, y);
    chk("result", result, e[W-1:0]);
    chk("zero", {31'b0, zero}, {31'b0, e[W-1:0] == '0});
    chk("overflow", {31'b0, overflow}, {31'b0, e[W]});
  endtask

  // Called just after a negedge while the unit is idle or in its done cycle.
  task automatic issue(input logic [3:0] c, input logic [W-1:0] x, y, input bit poke);
    logic [63:0] e;
    int n;
    bit got;
    e = ref_mdu(c, x, y);
    alucontrol = c;
    a = x;
    b = y;
    start = 1'b1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    alucontrol = MFLO;
    a = $urandom;
    b = $urandom;
    n = 0;
    got = 1'b0;
    while (n < 3 * W && !got) begin
      @(negedge clk);
      n++;
      if (done) got = 1'b1;
      else begin
        chk("busy_run", {31'b0, busy}, 32'd1);
        if (n == W / 2) chk("mflo_midrun_old", result, lo_m);
        #1;
        start = poke && n >= 5 && n < 8;
        alucontrol = start ? DIVU : MFLO;
        a = $urandom;
        b = $urandom;
      end
    end
    chk("latency", n, W + 1);
    chk("busy_in_done", {31'b0, busy}, 32'd0);
    {hi_m, lo_m} = e;
  endtask

  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done got=1 exp=0");
      end else chk("lo_at_done", result, sb.pop_front()[W-1:0]);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] c;
    @(negedge clk);
    alucontrol = MFHI;
    #1 chk("reset_hi", result, 0);
    alucontrol = MFLO;
    #1 chk("reset_lo", result, 0);
    chk("reset_busy", {31'b0, busy}, 0);
    chk("reset_done", {31'b0, done}, 0);
    @(negedge clk);
    reset = 1'b0;
    comb(4'd2, 32'h7FFF_FFFF, 32'd1);
    chk("add_ovf_result", result, 32'h8000_0000);
    chk("add_ovf_flag", {31'b0, overflow}, 32'd1);
    comb(4'd6, 32'd5, 32'd5);
    chk("sub_zero", {31'b0, zero}, 32'd1);
    comb(4'd7, 32'hFFFF_FFFF, 32'd1);
    chk("slt_neg", result, 32'd1);
    comb(4'd5, 32'hFFFF_FFFF, 32'd1);
    chk("sltu_big", result, 32'd0);
    comb(4'd10, 32'd4, 32'h8000_0000);
    chk("sra", result, 32'hF800_0000);
    comb(4'd4, 32'd0, 32'd0);
    chk("nor_zero", result, 32'hFFFF_FFFF);
    comb(4'd6, 32'h8000_0000, 32'd1);
    comb(4'd2, 32'h8000_0000, 32'h8000_0000);
    for (int i = 0; i < 150; i++) comb(4'($urandom_range(0, 12)), $urandom, $urandom);
    @(negedge clk);
    #1 issue(MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0);
    #1 alucontrol = MFHI;
    #1 chk("multu_hi", result, 32'd1);
    @(negedge clk);
    #1 issue(MULT, 32'hFFFF_FFFD, 32'd7, 1'b1);
    #1 alucontrol = MFHI;
    #1 chk("mult_hi", result, 32'hFFFF_FFFF);
    @(negedge clk);
    #1 issue(DIVU, 32'd100, 32'd7, 1'b0);
    #1 issue(DIVU, 32'd100, 32'd0, 1'b0);
    #1 alucontrol = MFHI;
    #1 chk("divu0_hi", result, 32'd100);
    @(negedge clk);
    #1;
    alucontrol = DIVU;
    a = 32'd100;
    b = 32'd7;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    alucontrol = MFLO;
    repeat (9) @(negedge clk);
    chk("busy_before_reset", {31'b0, busy}, 32'd1);
    #2 reset = 1'b1;
    #1 chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_lo", result, 0);
    alucontrol = MFHI;
    #1 chk("rst_hi", result, 0);
    hi_m = '0;
    lo_m = '0;
    @(negedge clk);
    reset = 1'b0;
    repeat (2 * W) @(negedge clk);
    chk("idle_after_reset", {31'b0, busy}, 0);
    #1 issue(MULTU, 32'd3, 32'd4, 1'b0);
    for (int i = 0; i < 15; i++) begin
      c = 4'($urandom_range(13, 15));
      #1 issue(c, $urandom, ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 5)) : $urandom, i % 3 == 0);
      if ($urandom_range(0, 1) == 1) begin
        #1 alucontrol = MFHI;
        #1 chk("mfhi_done", result, hi_m);
      end
    end
    repeat (5) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
